// File: rtl/ethernet_pkg.sv
// rtl/ethernet_pkg.sv - shared types and constants for the ethernet TX buffer
package ethernet_pkg;

    typedef enum logic {
        st_idle = 1'b0,
        st_send = 1'b1
    } tx_state_e;

    localparam int min_frame_len_c = 60;

    typedef enum logic [1:0] {
        op_size_1b  = 2'd0,
        op_size_2b  = 2'd1,
        op_size_4b  = 2'd2,
        op_size_bad = 2'd3
    } op_size_e;

    // Byte-lane mask of a write before it is shifted to its lane; zero marks an illegal size.
    function automatic logic [3:0] op_mask(input logic [1:0] size);
        case (op_size_e'(size))
            op_size_1b: op_mask = 4'b0001;
            op_size_2b: op_mask = 4'b0011;
            op_size_4b: op_mask = 4'b1111;
            default:    op_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] op_bytes(input logic [1:0] size);
        case (op_size_e'(size))
            op_size_1b: op_bytes = 3'd1;
            op_size_2b: op_bytes = 3'd2;
            op_size_4b: op_bytes = 3'd4;
            default:    op_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/ethernet_tx_ram.sv
// rtl/ethernet_tx_ram.sv - word-wide frame RAM, byte-masked write port, registered read port
module ethernet_tx_ram #(
    parameter int words_p  = 512,
    parameter int addr_w_p = 9
) (
    input  logic                clk,
    input  logic                wen,
    input  logic [addr_w_p-1:0] waddr,
    input  logic [3:0]          wmask,
    input  logic [31:0]         wdata,
    input  logic [addr_w_p-1:0] raddr,
    output logic [31:0]         rdata
);

    logic [31:0] mem [words_p];

    always_ff @(posedge clk) begin
        if (wen) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ethernet_tx_buffer.sv
// rtl/ethernet_tx_buffer.sv - MMIO-filled TX frame buffer streaming bytes to a MAC
// Optional ETH_TX_PAD_EN: zero-pads short frames up to the minimum frame length.
module ethernet_tx_buffer
    import ethernet_pkg::*;
#(
    parameter int eth_mtu_p    = 2048,
    parameter int data_width_p = 32
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           packet_send_i,
    output logic                           packet_req_o,
    input  logic                           packet_wsize_valid_i,
    input  logic [$clog2(eth_mtu_p+1)-1:0] packet_wsize_i,
    input  logic                           packet_wvalid_i,
    input  logic [$clog2(eth_mtu_p)-1:0]   packet_waddr_i,
    input  logic [data_width_p-1:0]        packet_wdata_i,
    input  logic [1:0]                     packet_wdata_size_i,
    input  logic                           tx_interrupt_clear_i,
    input  logic                           tx_interrupt_enable_i,
    input  logic                           tx_interrupt_enable_v_i,
    output logic                           tx_interrupt_pending_o,
    output logic                           tx_irq_o,
    output logic [7:0]                     m_axis_tdata_o,
    output logic                           m_axis_tvalid_o,
    input  logic                           m_axis_tready_i,
    output logic                           m_axis_tlast_o
);

    localparam int len_w_lp  = $clog2(eth_mtu_p + 1);
    localparam int addr_w_lp = $clog2(eth_mtu_p);
    localparam int word_w_lp = addr_w_lp - 2;
    localparam logic [len_w_lp-1:0] mtu_len_lp = len_w_lp'(eth_mtu_p);
    localparam logic [len_w_lp-1:0] one_lp     = len_w_lp'(1);

    tx_state_e             state_q, state_d;
    logic [len_w_lp-1:0]   len_q;
    logic [len_w_lp-1:0]   ptr_q, ptr_d;
    logic [len_w_lp-1:0]   frame_len;
    logic [7:0]            tdata_q;
    logic                  tvalid_q, tlast_q;
    logic                  pending_q, enable_q;
    logic                  load, finish, idle;

    logic [1:0]            lane;
    logic [3:0]            base_mask, wr_mask;
    logic [31:0]           wr_data;
    logic                  wr_ok, wr_en;
    logic [31:0]           ram_rdata;
    logic [7:0]            rd_byte;

    assign idle      = (state_q == st_idle);
    assign lane      = packet_waddr_i[1:0];
    assign base_mask = op_mask(packet_wdata_size_i);
    assign wr_ok     = (base_mask != 4'b0000)
                    && (({1'b0, lane} + op_bytes(packet_wdata_size_i)) <= 3'd4);
    assign wr_en     = packet_wvalid_i && idle && wr_ok;
    assign wr_mask   = base_mask << lane;
    assign wr_data   = 32'(packet_wdata_i) << {lane, 3'b000};

`ifdef ETH_TX_PAD_EN
    assign frame_len = (len_q < len_w_lp'(min_frame_len_c)) ? len_w_lp'(min_frame_len_c) : len_q;
`else
    assign frame_len = len_q;
`endif

    // Read address follows the next pointer so the word holding ptr_q is always in rdata.
    ethernet_tx_ram #(
        .words_p  (eth_mtu_p / 4),
        .addr_w_p (word_w_lp)
    ) u_ram (
        .clk   (clk_i),
        .wen   (wr_en),
        .waddr (packet_waddr_i[addr_w_lp-1:2]),
        .wmask (wr_mask),
        .wdata (wr_data),
        .raddr (ptr_d[addr_w_lp-1:2]),
        .rdata (ram_rdata)
    );

    assign rd_byte = ram_rdata[{ptr_q[1:0], 3'b000} +: 8];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        load    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            st_idle: begin
                if (packet_send_i && (len_q != '0)) begin
                    state_d = st_send;
                    ptr_d   = '0;
                end
            end
            st_send: begin
                if (tvalid_q && m_axis_tready_i && tlast_q) begin
                    finish  = 1'b1;
                    state_d = st_idle;
                end else if (!tvalid_q || m_axis_tready_i) begin
                    load  = 1'b1;
                    ptr_d = ptr_q + one_lp;
                end
            end
            default: state_d = st_idle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q     <= '0;
            len_q     <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            pending_q <= 1'b0;
            enable_q  <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            if (idle && packet_wsize_valid_i) begin
                len_q <= (packet_wsize_i > mtu_len_lp) ? mtu_len_lp : packet_wsize_i;
            end
            if (load) begin
                tvalid_q <= 1'b1;
                tdata_q  <= (ptr_q < len_q) ? rd_byte : 8'h00;
                tlast_q  <= (ptr_q == frame_len - one_lp);
            end else if (finish) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                tdata_q  <= 8'h00;
            end
            if (finish) begin
                pending_q <= 1'b1;
            end else if (tx_interrupt_clear_i) begin
                pending_q <= 1'b0;
            end
            if (tx_interrupt_enable_v_i) begin
                enable_q <= tx_interrupt_enable_i;
            end
        end
    end

    assign packet_req_o           = idle;
    assign m_axis_tdata_o         = tdata_q;
    assign m_axis_tvalid_o        = tvalid_q;
    assign m_axis_tlast_o         = tlast_q;
    assign tx_interrupt_pending_o = pending_q;
    assign tx_irq_o               = pending_q & enable_q;

endmodule

// File: tb/tb_ethernet_tx_buffer.sv
// tb/tb_ethernet_tx_buffer.sv - scoreboard bench for ethernet_tx_buffer
module tb_ethernet_tx_buffer;

    localparam int MTU = 2048;
    localparam int LW  = $clog2(MTU + 1);
    localparam int AW  = $clog2(MTU);
`ifdef ETH_TX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_i;
    logic          packet_send_i;
    logic          packet_req_o;
    logic          packet_wsize_valid_i;
    logic [LW-1:0] packet_wsize_i;
    logic          packet_wvalid_i;
    logic [AW-1:0] packet_waddr_i;
    logic [31:0]   packet_wdata_i;
    logic [1:0]    packet_wdata_size_i;
    logic          tx_interrupt_clear_i;
    logic          tx_interrupt_enable_i;
    logic          tx_interrupt_enable_v_i;
    logic          tx_interrupt_pending_o;
    logic          tx_irq_o;
    logic [7:0]    m_axis_tdata_o;
    logic          m_axis_tvalid_o;
    logic          m_axis_tready_i;
    logic          m_axis_tlast_o;

    logic [7:0] mem_model [MTU];
    logic [8:0] exp_q [$];
    int         cur_len = 0;
    int         checks  = 0;
    int         errors  = 0;

    ethernet_tx_buffer #(.eth_mtu_p(MTU), .data_width_p(32)) dut (
        .clk_i                   (clk),
        .reset_i                 (reset_i),
        .packet_send_i           (packet_send_i),
        .packet_req_o            (packet_req_o),
        .packet_wsize_valid_i    (packet_wsize_valid_i),
        .packet_wsize_i          (packet_wsize_i),
        .packet_wvalid_i         (packet_wvalid_i),
        .packet_waddr_i          (packet_waddr_i),
        .packet_wdata_i          (packet_wdata_i),
        .packet_wdata_size_i     (packet_wdata_size_i),
        .tx_interrupt_clear_i    (tx_interrupt_clear_i),
        .tx_interrupt_enable_i   (tx_interrupt_enable_i),
        .tx_interrupt_enable_v_i (tx_interrupt_enable_v_i),
        .tx_interrupt_pending_o  (tx_interrupt_pending_o),
        .tx_irq_o                (tx_irq_o),
        .m_axis_tdata_o          (m_axis_tdata_o),
        .m_axis_tvalid_o         (m_axis_tvalid_o),
        .m_axis_tready_i         (m_axis_tready_i),
        .m_axis_tlast_o          (m_axis_tlast_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [31:0] data, input logic [1:0] size);
        int lane = addr % 4;
        int nb   = 1 << size;
        packet_wvalid_i     = 1'b1;
        packet_waddr_i      = addr[AW-1:0];
        packet_wdata_i      = data;
        packet_wdata_size_i = size;
        step();
        packet_wvalid_i = 1'b0;
        if (size != 2'd3 && lane + nb <= 4) begin
            for (int i = 0; i < nb; i++) mem_model[addr + i] = data[8*i +: 8];
        end
    endtask

    task automatic set_len(input int n);
        packet_wsize_valid_i = 1'b1;
        packet_wsize_i       = n[LW-1:0];
        step();
        packet_wsize_valid_i = 1'b0;
        cur_len = (n > MTU) ? MTU : n;
    endtask

    task automatic send_frame();
        int n = (PAD && cur_len > 0 && cur_len < 60) ? 60 : cur_len;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), (i < cur_len) ? mem_model[i] : 8'h00});
        end
        packet_send_i = 1'b1;
        step();
        packet_send_i = 1'b0;
    endtask

    task automatic collect(input bit toggle, input int max_hs, input bit clr_last, output int hs);
        int         cyc = 0;
        int         budget = 4 * exp_q.size() + 20;
        bit         stalled = 1'b0;
        logic [7:0] sd = 8'h00;
        logic       sl = 1'b0;
        logic [8:0] e;
        hs = 0;
        while (exp_q.size() > 0 && hs < max_hs && cyc < budget) begin
            m_axis_tready_i = toggle ? (cyc % 2 == 0) : 1'b1;
            if (stalled) begin
                checks++;
                if (m_axis_tvalid_o !== 1'b1 || m_axis_tdata_o !== sd || m_axis_tlast_o !== sl) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                             m_axis_tvalid_o, m_axis_tdata_o, m_axis_tlast_o, sd, sl);
                end
            end
            stalled = m_axis_tvalid_o && !m_axis_tready_i;
            sd = m_axis_tdata_o;
            sl = m_axis_tlast_o;
            if (m_axis_tvalid_o && m_axis_tready_i) begin
                e = exp_q.pop_front();
                checks++;
                if (m_axis_tdata_o !== e[7:0] || m_axis_tlast_o !== e[8]) begin
                    errors++;
                    $display("FAIL byte[%0d]: got data=%h last=%b, want data=%h last=%b",
                             hs, m_axis_tdata_o, m_axis_tlast_o, e[7:0], e[8]);
                end
                if (e[8] && clr_last) tx_interrupt_clear_i = 1'b1;
                hs++;
            end
            step();
            tx_interrupt_clear_i = 1'b0;
            cyc++;
        end
        m_axis_tready_i = 1'b1;
        checks++;
        if (exp_q.size() != 0 && hs < max_hs) begin
            errors++;
            $display("FAIL collect_timeout: got %0d bytes, %0d still expected", hs, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle(input string tag, input logic want_pending);
        checks++;
        if (m_axis_tvalid_o !== 1'b0 || packet_req_o !== 1'b1 || tx_interrupt_pending_o !== want_pending) begin
            errors++;
            $display("FAIL %s: got valid=%b req=%b pending=%b, want valid=0 req=1 pending=%b",
                     tag, m_axis_tvalid_o, packet_req_o, tx_interrupt_pending_o, want_pending);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        step();
        step();
        checks++;
        if (packet_req_o !== 1'b1 || m_axis_tvalid_o !== 1'b0 || m_axis_tlast_o !== 1'b0 ||
            m_axis_tdata_o !== 8'h00 || tx_interrupt_pending_o !== 1'b0 || tx_irq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got req=%b valid=%b last=%b data=%h pending=%b irq=%b, want 1 0 0 00 0 0",
                     packet_req_o, m_axis_tvalid_o, m_axis_tlast_o, m_axis_tdata_o, tx_interrupt_pending_o, tx_irq_o);
        end
        reset_i = 1'b0;
        step();
    endtask

    task automatic test_zero_len();
        send_frame();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_axis_tvalid_o !== 1'b0 || packet_req_o !== 1'b1) begin
                errors++;
                $display("FAIL zero_len_ignored: got valid=%b req=%b, want valid=0 req=1", m_axis_tvalid_o, packet_req_o);
            end
            step();
        end
        check_idle("zero_len_no_event", 1'b0);
    endtask

    task automatic test_full_frame();
        int hs;
        for (int k = 0; k < 16; k++) wr(4 * k, 32'h03020100 + 32'(k) * 32'h04040404, 2'd2);
        set_len(64);
        send_frame();
        checks++;
        if (m_axis_tvalid_o !== 1'b0 || packet_req_o !== 1'b0) begin
            errors++;
            $display("FAIL send_latency_1: got valid=%b req=%b, want valid=0 req=0", m_axis_tvalid_o, packet_req_o);
        end
        step();
        checks++;
        if (m_axis_tvalid_o !== 1'b1 || m_axis_tdata_o !== 8'h00) begin
            errors++;
            $display("FAIL send_latency_2: got valid=%b data=%h, want valid=1 data=00", m_axis_tvalid_o, m_axis_tdata_o);
        end
        collect(1'b0, 1000, 1'b0, hs);
        checks++;
        if (hs !== 64) begin
            errors++;
            $display("FAIL full_frame_count: got %0d, want 64", hs);
        end
        check_idle("full_frame_done", 1'b1);
    endtask

    task automatic test_byte_writes();
        int hs;
        wr(5, 32'h000000AB, 2'd0);
        wr(6, 32'h0000CDEF, 2'd1);
        wr(3, 32'h00009999, 2'd1);
        wr(0, 32'hFFFFFFFF, 2'd3);
        set_len(8);
        send_frame();
        collect(1'b0, 1000, 1'b0, hs);
        check_idle("byte_writes_done", 1'b1);
    endtask

    task automatic test_stall();
        int hs;
        set_len(10);
        send_frame();
        collect(1'b1, 1000, 1'b0, hs);
        checks++;
        if (hs !== (PAD ? 60 : 10)) begin
            errors++;
            $display("FAIL stall_count: got %0d, want %0d", hs, PAD ? 60 : 10);
        end
        check_idle("stall_done", 1'b1);
    endtask

    task automatic test_pad();
        int hs;
        set_len(20);
        send_frame();
        collect(1'b0, 1000, 1'b0, hs);
        checks++;
        if (hs !== (PAD ? 60 : 20)) begin
            errors++;
            $display("FAIL pad_count: got %0d, want %0d", hs, PAD ? 60 : 20);
        end
        check_idle("pad_done", 1'b1);
    endtask

    task automatic test_resend_ignores_writes();
        int hs;
        send_frame();
        packet_wvalid_i      = 1'b1;
        packet_waddr_i       = '0;
        packet_wdata_i       = 32'hFFFFFFFF;
        packet_wdata_size_i  = 2'd2;
        packet_wsize_valid_i = 1'b1;
        packet_wsize_i       = LW'(4);
        packet_send_i        = 1'b1;
        step();
        packet_wvalid_i      = 1'b0;
        packet_wsize_valid_i = 1'b0;
        packet_send_i        = 1'b0;
        collect(1'b0, 1000, 1'b0, hs);
        checks++;
        if (hs !== (PAD ? 60 : 20)) begin
            errors++;
            $display("FAIL resend_count: got %0d, want %0d", hs, PAD ? 60 : 20);
        end
        check_idle("resend_done", 1'b1);
    endtask

    task automatic test_irq_clear();
        int hs;
        tx_interrupt_clear_i = 1'b1;
        step();
        tx_interrupt_clear_i = 1'b0;
        check_idle("clear_pending", 1'b0);
        tx_interrupt_enable_i   = 1'b1;
        tx_interrupt_enable_v_i = 1'b1;
        step();
        tx_interrupt_enable_v_i = 1'b0;
        checks++;
        if (tx_irq_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_no_pending: got %b, want 0", tx_irq_o);
        end
        set_len(4);
        send_frame();
        collect(1'b0, 1000, 1'b1, hs);
        tx_interrupt_enable_i = 1'b0;
        step();
        checks++;
        if (tx_interrupt_pending_o !== 1'b1 || tx_irq_o !== 1'b1) begin
            errors++;
            $display("FAIL set_over_clear: got pending=%b irq=%b, want 1 1", tx_interrupt_pending_o, tx_irq_o);
        end
        tx_interrupt_clear_i = 1'b1;
        step();
        tx_interrupt_clear_i = 1'b0;
        checks++;
        if (tx_interrupt_pending_o !== 1'b0 || tx_irq_o !== 1'b0) begin
            errors++;
            $display("FAIL late_clear: got pending=%b irq=%b, want 0 0", tx_interrupt_pending_o, tx_irq_o);
        end
    endtask

    task automatic test_reset_mid_frame();
        int hs;
        set_len(64);
        send_frame();
        collect(1'b0, 7, 1'b0, hs);
        checks++;
        if (m_axis_tvalid_o !== 1'b1 || m_axis_tdata_o !== mem_model[7]) begin
            errors++;
            $display("FAIL byte7_present: got valid=%b data=%h, want valid=1 data=%h",
                     m_axis_tvalid_o, m_axis_tdata_o, mem_model[7]);
        end
        reset_i = 1'b1;
        step();
        checks++;
        if (m_axis_tvalid_o !== 1'b0 || m_axis_tlast_o !== 1'b0 || tx_interrupt_pending_o !== 1'b0 ||
            packet_req_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_abort: got valid=%b last=%b pending=%b req=%b, want 0 0 0 1",
                     m_axis_tvalid_o, m_axis_tlast_o, tx_interrupt_pending_o, packet_req_o);
        end
        reset_i = 1'b0;
        exp_q.delete();
        step();
        step();
        check_idle("after_abort", 1'b0);
    endtask

    initial begin
        reset_i                 = 1'b1;
        packet_send_i           = 1'b0;
        packet_wsize_valid_i    = 1'b0;
        packet_wsize_i          = '0;
        packet_wvalid_i         = 1'b0;
        packet_waddr_i          = '0;
        packet_wdata_i          = '0;
        packet_wdata_size_i     = 2'd0;
        tx_interrupt_clear_i    = 1'b0;
        tx_interrupt_enable_i   = 1'b0;
        tx_interrupt_enable_v_i = 1'b0;
        m_axis_tready_i         = 1'b1;
        for (int i = 0; i < MTU; i++) mem_model[i] = 8'h00;

        test_reset();
        test_zero_len();
        test_full_frame();
        test_byte_writes();
        test_stall();
        test_pad();
        test_resend_ignores_writes();
        test_irq_clear();
        test_reset_mid_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ethernet_tx_buffer.md
ETHERNET_TX_BUFFER -- requirements
Module: ethernet_tx_buffer

Interface
REQ-001 SHALL have parameter eth_mtu_p, default 2048, TX buffer capacity in bytes (power of 2, <= 2048).
REQ-002 SHALL have parameter data_width_p, default 32, MMIO write word width in bits (only 32 supported).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port packet_send_i  input  1  one-cycle pulse requesting transmission of the buffered frame.
REQ-006 SHALL have port packet_req_o  output  1  block is idle and accepts writes and sends.
REQ-007 SHALL have port packet_wsize_valid_i  input  1  frame length write strobe.
REQ-008 SHALL have port packet_wsize_i  input  $clog2(eth_mtu_p+1)  frame length in bytes.
REQ-009 SHALL have port packet_wvalid_i  input  1  buffer write strobe.
REQ-010 SHALL have port packet_waddr_i  input  $clog2(eth_mtu_p)  byte address of write.
REQ-011 SHALL have port packet_wdata_i  input  data_width_p  write data, LSB-aligned.
REQ-012 SHALL have port packet_wdata_size_i  input  2  log2 of write bytes (0=1B, 1=2B, 2=4B).
REQ-013 SHALL have port tx_interrupt_clear_i  input  1  pulse clearing pending bit.
REQ-014 SHALL have ports tx_interrupt_enable_i / tx_interrupt_enable_v_i  input  1 / 1  enable value and its write strobe.
REQ-015 SHALL have port tx_interrupt_pending_o  output  1  frame-sent event pending.
REQ-016 SHALL have port tx_irq_o  output  1  pending AND enable.
REQ-017 SHALL have ports m_axis_tdata_o  output  8, m_axis_tvalid_o  output  1, m_axis_tready_i  input  1, m_axis_tlast_o  output  1  byte stream to MAC.

Function
REQ-018 SHALL store writes in a word-wide RAM with byte mask; lane = waddr[1:0], data shifted left by 8*waddr[1:0].
REQ-019 SHALL silently drop writes whose bytes cross a 4-byte boundary, and size 3.
REQ-020 SHALL latch packet_wsize_i on packet_wsize_valid_i, clamped to eth_mtu_p.
REQ-021 SHALL implement FSM IDLE -> SEND -> IDLE; packet_req_o=1 only in IDLE.
REQ-022 SHALL in IDLE on packet_send_i with latched length > 0 enter SEND; length 0 send ignored (no event).
REQ-023 SHALL ignore buffer writes, length writes and packet_send_i while in SEND.
REQ-024 SHALL emit bytes in ascending address order from 0, first tvalid 2 cycles after send pulse, then one byte per cycle while tready=1 (prefetch next word, sync-read RAM latency 1).
REQ-025 SHALL hold tdata/tlast stable while tvalid=1 and tready=0; tvalid never drops mid-frame.
REQ-026 SHALL assert tlast with final byte; on its handshake return to IDLE and set pending.
REQ-027 SHALL give set priority when pending set and tx_interrupt_clear_i coincide.
REQ-028 SHALL update enable only on tx_interrupt_enable_v_i; tx_irq_o combinational from registered pending and enable.
REQ-029 SHALL preserve buffer contents and latched length after a send (resend allowed).

Reset
REQ-030 SHALL on reset_i: FSM=IDLE, packet_req_o=1, tvalid/tlast=0, tdata=0, pending=0, enable=0, length=0, tx_irq_o=0; RAM contents undefined.
REQ-031 SHALL abort any in-flight frame on reset mid-SEND without asserting tlast or pending.

Configuration
REQ-032 SHALL support macro ETH_TX_PAD_EN: defined -> frames with length < 60 emitted as 60 bytes, bytes past length = 0x00, tlast on byte 60; undefined -> exactly length bytes.

Structure
REQ-033 SHALL place FSM state enum, minimum frame length (60) and op-size encoding in shared package ethernet_pkg.
REQ-034 SHALL instantiate one sub-module ethernet_tx_ram (1rw-per-port sync RAM, byte-masked write, eth_mtu_p/4 words x 32).

Verification
REQ-035 SHALL cover: 4B writes 0x03020100.. to addr 0..0x3C, length 64, send, tready=1 -> 64 bytes 0x00..0x3F, tlast on 64th, pending=1.
REQ-036 SHALL cover: 1B write 0xAB at addr 0x5, 2B write 0xCDEF at addr 0x6 -> bytes 5..7 read AB,EF,CD; 2B write at addr 0x3 dropped.
REQ-037 SHALL cover: length 10, tready toggling 1/0 each cycle -> 10 bytes, data stable during stalls, single tlast.
REQ-038 SHALL cover: length 20 with/without ETH_TX_PAD_EN -> 60 bytes (40 zeros) / 20 bytes.
REQ-039 SHALL cover: enable=1, clear same cycle as final handshake -> pending=1, tx_irq_o=1; later clear -> both 0.
REQ-040 SHALL cover: reset asserted at byte 7 of 64-byte frame -> tvalid=0 next cycle, pending=0, packet_req_o=1.
